// File: rtl/hap_pkg.sv
// hap_pkg: shared opcodes, instruction field positions and sequencer states for the HAP front end.
package hap_pkg;
   localparam logic [4:0] OPC_CMP  = 5'b01000;
   localparam logic [4:0] OPC_BRT  = 5'b11000;
   localparam logic [4:0] OPC_JMP  = 5'b11001;
   localparam logic [4:0] OPC_HALT = 5'b11111;
   localparam int OPC_HI = 15;
   localparam int OPC_LO = 11;
   localparam int RD_HI  = 10;
   localparam int RD_LO  = 8;
   localparam int R1_HI  = 7;
   localparam int R1_LO  = 5;
   localparam int R2_HI  = 4;
   localparam int R2_LO  = 2;
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, WAIT_CMP, HALT} state_e;
endpackage

// File: rtl/hap_instr_decode.sv
// hap_instr_decode: combinational split of an instruction word into fields and class flags.
module hap_instr_decode #(
   parameter int PC_W = 8
) (
   input  logic [15:0]     ir_i,
   output logic [4:0]      opcode_o,
   output logic [2:0]      rd_o,
   output logic [2:0]      r1_o,
   output logic [2:0]      r2_o,
   output logic [PC_W-1:0] target_o,
   output logic            is_branch_o,
   output logic            is_jmp_o,
   output logic            is_halt_o,
   output logic            is_cmp_o
);
   import hap_pkg::*;
   assign opcode_o    = ir_i[OPC_HI:OPC_LO];
   assign rd_o        = ir_i[RD_HI:RD_LO];
   assign r1_o        = ir_i[R1_HI:R1_LO];
   assign r2_o        = ir_i[R2_HI:R2_LO];
   assign target_o    = ir_i[PC_W-1:0];
   assign is_branch_o = opcode_o == OPC_BRT;
   assign is_jmp_o    = opcode_o == OPC_JMP;
   assign is_halt_o   = opcode_o == OPC_HALT;
   assign is_cmp_o    = opcode_o == OPC_CMP;
endmodule

// File: rtl/hap_instr_sequencer.sv
// hap_instr_sequencer: fetch/decode/issue FSM with pc, compare-flag tracking and conditional branches.
module hap_instr_sequencer
   import hap_pkg::*;
#(
   parameter int PC_W = 8
) (
   input  logic            Clk,
   input  logic            Rst_n,
   input  logic            run,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_valid,
   input  logic [15:0]     imem_data,
   output logic            issue_valid,
   input  logic            ex_ready,
   output logic [4:0]      opcode,
   output logic [2:0]      RD,
   output logic [2:0]      R1,
   output logic [2:0]      R2,
   input  logic            cmp_valid,
   input  logic            cmp_flag,
   output logic            halted
);
   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;
   logic            flag_q, flag_d, req_q, req_d, iv_q, iv_d, halted_q, halted_d;
   logic [4:0]      opc_q, opc_d;
   logic [2:0]      rd_q, rd_d, r1_q, r1_d, r2_q, r2_d;
   logic [4:0]      dec_opc;
   logic [2:0]      dec_rd, dec_r1, dec_r2;
   logic [PC_W-1:0] dec_target;
   logic            dec_is_branch, dec_is_jmp, dec_is_halt, dec_is_cmp;

   hap_instr_decode #(.PC_W(PC_W)) u_dec (
      .ir_i(ir_q), .opcode_o(dec_opc), .rd_o(dec_rd), .r1_o(dec_r1), .r2_o(dec_r2),
      .target_o(dec_target), .is_branch_o(dec_is_branch), .is_jmp_o(dec_is_jmp),
      .is_halt_o(dec_is_halt), .is_cmp_o(dec_is_cmp)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         ir_q     <= '0;
         flag_q   <= 1'b0;
         req_q    <= 1'b0;
         iv_q     <= 1'b0;
         halted_q <= 1'b0;
         opc_q    <= '0;
         rd_q     <= '0;
         r1_q     <= '0;
         r2_q     <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         flag_q   <= flag_d;
         req_q    <= req_d;
         iv_q     <= iv_d;
         halted_q <= halted_d;
         opc_q    <= opc_d;
         rd_q     <= rd_d;
         r1_q     <= r1_d;
         r2_q     <= r2_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      flag_d   = flag_q;
      req_d    = req_q;
      iv_d     = iv_q;
      halted_d = halted_q;
      opc_d    = opc_q;
      rd_d     = rd_q;
      r1_d     = r1_q;
      r2_d     = r2_q;
      case (state_q)
         IDLE: if (run) begin
            state_d = FETCH;
            req_d   = 1'b1;
         end
         FETCH: if (imem_valid) begin
            ir_d    = imem_data;
            req_d   = 1'b0;
            state_d = DECODE;
         end
         DECODE: if (dec_is_jmp || dec_is_branch) begin
            pc_d    = (dec_is_jmp || flag_q) ? dec_target : pc_q + 1'b1;
            req_d   = 1'b1;
            state_d = FETCH;
         end else if (dec_is_halt) begin
            halted_d = 1'b1;
            state_d  = HALT;
         end else begin
            opc_d   = dec_opc;
            rd_d    = dec_rd;
            r1_d    = dec_r1;
            r2_d    = dec_r2;
            iv_d    = 1'b1;
            state_d = ISSUE;
         end
         // ir_q still holds the issued word, so the decoder tells us whether to await a flag
         ISSUE: if (ex_ready) begin
            iv_d    = 1'b0;
            pc_d    = pc_q + 1'b1;
            req_d   = !dec_is_cmp;
            state_d = dec_is_cmp ? WAIT_CMP : FETCH;
         end
         WAIT_CMP: if (cmp_valid) begin
            flag_d  = cmp_flag;
            req_d   = 1'b1;
            state_d = FETCH;
         end
         default: ;
      endcase
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign issue_valid = iv_q;
   assign opcode      = opc_q;
   assign RD          = rd_q;
   assign R1          = r1_q;
   assign R2          = r2_q;
   assign halted      = halted_q;
endmodule

// File: tb/tb_hap_instr_sequencer.sv
// tb_hap_instr_sequencer: directed scenario tasks against hand-computed fetch addresses and fields.
module tb_hap_instr_sequencer;
   logic        Clk, Rst_n, run, imem_req, imem_valid, issue_valid, ex_ready, cmp_valid, cmp_flag, halted;
   logic [7:0]  imem_addr;
   logic [15:0] imem_data;
   logic [4:0]  opcode;
   logic [2:0]  RD, R1, R2;
   int          checks = 0, passes = 0;
   logic [7:0]  a;
   logic        ok;

   hap_instr_sequencer #(.PC_W(8)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_data(imem_data), .issue_valid(issue_valid),
      .ex_ready(ex_ready), .opcode(opcode), .RD(RD), .R1(R1), .R2(R2),
      .cmp_valid(cmp_valid), .cmp_flag(cmp_flag), .halted(halted)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic do_fetch(input logic [15:0] instr, input int lat, output logic [7:0] addr, output logic found);
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (imem_req) begin
            found = 1'b1;
            break;
         end
         @(negedge Clk);
      end
      addr = imem_addr;
      if (found) begin
         repeat (lat - 1) @(negedge Clk);
         imem_valid = 1'b1;
         imem_data  = instr;
         @(negedge Clk);
         imem_valid = 1'b0;
      end
   endtask

   task automatic pulse_run();
      run = 1'b1;
      @(negedge Clk);
      run = 1'b0;
   endtask

   task automatic handshake();
      ex_ready = 1'b1;
      @(negedge Clk);
      ex_ready = 1'b0;
   endtask

   task automatic test_reset();
      Rst_n = 1'b0;
      #1;
      checks++;
      if ({imem_req, imem_addr, issue_valid, opcode, RD, R1, R2, halted} !== 24'h0)
         $display("FAIL reset_outputs got %h want 0", {imem_req, imem_addr, issue_valid, opcode, RD, R1, R2, halted});
      else passes++;
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
      checks++;
      if ({imem_req, issue_valid, halted} !== 3'b000) $display("FAIL idle_no_req got %b want 000", {imem_req, issue_valid, halted});
      else passes++;
   endtask

   task automatic test_first_fetch();
      pulse_run();
      do_fetch(16'h1234, 2, a, ok);
      checks++;
      if (!ok || a !== 8'h00) $display("FAIL first_fetch_addr got %h found=%b want 00", a, ok);
      else passes++;
      @(negedge Clk);
      checks++;
      if ({issue_valid, opcode, RD, R1, R2, imem_req} !== {1'b1, 5'h02, 3'd2, 3'd1, 3'd5, 1'b0})
         $display("FAIL first_issue got v=%b op=%h rd=%0d r1=%0d r2=%0d req=%b want v=1 op=02 rd=2 r1=1 r2=5 req=0",
                  issue_valid, opcode, RD, R1, R2, imem_req);
      else passes++;
   endtask

   task automatic test_issue_stall();
      logic bad;
      bad = 1'b0;
      ex_ready = 1'b0;
      repeat (3) begin
         @(negedge Clk);
         if ({issue_valid, opcode, RD, R1, R2} !== {1'b1, 5'h02, 3'd2, 3'd1, 3'd5}) bad = 1'b1;
      end
      checks++;
      if (bad) $display("FAIL issue_stall_stable got unstable fields want held");
      else passes++;
      handshake();
      checks++;
      if (issue_valid !== 1'b0) $display("FAIL issue_drop got %b want 0", issue_valid);
      else passes++;
      do_fetch(16'hC030, 1, a, ok);
      checks++;
      if (!ok || a !== 8'h01) $display("FAIL next_fetch_addr got %h want 01", a);
      else passes++;
      do_fetch(16'hC804, 1, a, ok);
      checks++;
      if (!ok || a !== 8'h02) $display("FAIL brt_no_flag got %h want 02", a);
      else passes++;
   endtask

   task automatic cmp_brt_round(input logic flag, input logic [7:0] want, input string nm);
      do_fetch(16'h4000, 1, a, ok);
      checks++;
      if (!ok || a !== 8'h04) $display("FAIL %s_cmp_addr got %h want 04", nm, a);
      else passes++;
      @(negedge Clk);
      handshake();
      repeat (2) @(negedge Clk);
      checks++;
      if ({imem_req, issue_valid} !== 2'b00) $display("FAIL %s_wait_cmp got req=%b v=%b want 0 0", nm, imem_req, issue_valid);
      else passes++;
      cmp_valid = 1'b1;
      cmp_flag  = flag;
      @(negedge Clk);
      cmp_valid = 1'b0;
      cmp_flag  = 1'b0;
      do_fetch(16'hC020, 1, a, ok);
      checks++;
      if (!ok || a !== 8'h05) $display("FAIL %s_brt_addr got %h want 05", nm, a);
      else passes++;
      for (int i = 0; i < 50 && !imem_req; i++) @(negedge Clk);
      checks++;
      if (imem_addr !== want) $display("FAIL %s_target got %h want %h", nm, imem_addr, want);
      else passes++;
   endtask

   task automatic test_cmp_branch();
      cmp_brt_round(1'b1, 8'h20, "taken");
      do_fetch(16'hC804, 1, a, ok);
      cmp_brt_round(1'b0, 8'h06, "not_taken");
   endtask

   task automatic test_wrap_jmp();
      do_fetch(16'hC8FF, 1, a, ok);
      do_fetch(16'h1234, 1, a, ok);
      checks++;
      if (!ok || a !== 8'hFF) $display("FAIL wrap_src got %h want ff", a);
      else passes++;
      @(negedge Clk);
      handshake();
      do_fetch(16'hC87A, 1, a, ok);
      checks++;
      if (!ok || a !== 8'h00) $display("FAIL pc_wrap got %h want 00", a);
      else passes++;
      for (int i = 0; i < 50 && !imem_req; i++) @(negedge Clk);
      checks++;
      if (imem_addr !== 8'h7A) $display("FAIL jmp_target got %h want 7a", imem_addr);
      else passes++;
   endtask

   task automatic test_halt();
      logic bad;
      bad = 1'b0;
      do_fetch(16'hF800, 1, a, ok);
      @(negedge Clk);
      checks++;
      if (halted !== 1'b1) $display("FAIL halted got %b want 1", halted);
      else passes++;
      for (int i = 0; i < 20; i++) begin
         run = (i % 4 == 0);
         @(negedge Clk);
         if ({imem_req, issue_valid, halted} !== 3'b001) bad = 1'b1;
      end
      run = 1'b0;
      checks++;
      if (bad) $display("FAIL halt_terminal got activity want req=0 v=0 halted=1");
      else passes++;
   endtask

   task automatic test_async_reset();
      Rst_n = 1'b0;
      @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
      pulse_run();
      do_fetch(16'h1234, 1, a, ok);
      @(negedge Clk);
      checks++;
      if (issue_valid !== 1'b1) $display("FAIL pre_reset_issue got %b want 1", issue_valid);
      else passes++;
      #2;
      Rst_n      = 1'b0;
      imem_valid = 1'b1;
      #1;
      checks++;
      if ({issue_valid, opcode, imem_req, halted} !== 8'h00)
         $display("FAIL async_clear got v=%b op=%h req=%b want 0", issue_valid, opcode, imem_req);
      else passes++;
      @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
      imem_valid = 1'b0;
      repeat (3) @(negedge Clk);
      checks++;
      if ({imem_req, issue_valid, imem_addr} !== 10'h0) $display("FAIL idle_after_reset got req=%b v=%b addr=%h", imem_req, issue_valid, imem_addr);
      else passes++;
      pulse_run();
      checks++;
      if ({imem_req, imem_addr} !== 9'h100) $display("FAIL restart got req=%b addr=%h want 1 00", imem_req, imem_addr);
      else passes++;
   endtask

   initial begin
      Rst_n = 1'b0; run = 1'b0; imem_valid = 1'b0; imem_data = '0;
      ex_ready = 1'b0; cmp_valid = 1'b0; cmp_flag = 1'b0;
      test_reset();
      test_first_fetch();
      test_issue_stall();
      test_cmp_branch();
      test_wrap_jmp();
      test_halt();
      test_async_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
